// File: rtl/johnson_pkg.sv
// ============================================================================
//  johnson_pkg
//  Shared types and helpers for the Johnson ring sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package johnson_pkg;

  localparam int unsigned JOHNSON_WIDTH     = 4;
  localparam int unsigned JOHNSON_MAX_WIDTH = 16;
  localparam int unsigned JOHNSON_SEQ_LEN   = 2 * JOHNSON_WIDTH;
  localparam int unsigned JOHNSON_IDX_W     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } johnson_state_t;

  // Position of a legal Johnson word within the forward sequence.
  function automatic logic [JOHNSON_IDX_W-1:0] johnson_index(
    input logic [JOHNSON_MAX_WIDTH-1:0] q,
    input int unsigned                  width
  );
    int unsigned p;
    p = 0;
    for (int unsigned i = 0; i < JOHNSON_MAX_WIDTH; i++) begin
      if (i < width) p = p + int'(q[i]);
    end
    if (q[width-1]) return JOHNSON_IDX_W'(2 * width - p);
    else            return JOHNSON_IDX_W'(p);
  endfunction

endpackage

`default_nettype wire

// File: rtl/johnson_core.sv
// ============================================================================
//  johnson_core
//  Twisted-ring register; steps one position per enabled clock.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module johnson_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (en) begin
      if (dir) r_q <= {~r_q[0], r_q[WIDTH-1:1]};
      else     r_q <= {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/johnson_seq_ctrl.sv
// ============================================================================
//  johnson_seq_ctrl
//  Runs a Johnson ring for a set number of revolutions with graceful stop.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic [CNT_W-1:0]   cycles,
  output logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] phase,
  output logic               wrap,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cycles_left
);

  localparam int SEQ_LEN = 2 * WIDTH;
  localparam logic [WIDTH-1:0] c_last_fwd = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_last_rev = WIDTH'(1);

  johnson_state_t   r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cl, w_cl_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_done, w_done_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic             w_en;
  logic             w_last;
  logic [JOHNSON_IDX_W-1:0] w_idx;

  johnson_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_en),
    .dir   (r_dir),
    .q     (q)
  );

  // The word one step before all-zeros in the latched direction.
  assign w_last = r_dir ? (q == c_last_rev) : (q == c_last_fwd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cl    <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cl    <= w_cl_nxt;
      r_dir   <= w_dir_nxt;
      r_done  <= w_done_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cl_nxt    = r_cl;
    w_dir_nxt   = r_dir;
    w_done_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_en        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          if (cycles != '0) begin
            w_cl_nxt    = cycles;
            w_dir_nxt   = dir;
            w_state_nxt = RUN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop && q == '0) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_cl_nxt    = '0;
        end else begin
          w_en = 1'b1;
          if (w_last) begin
            w_wrap_nxt = 1'b1;
            // A stop landing on a boundary ends the run right here.
            if (r_cl <= CNT_W'(1) || stop) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
              w_cl_nxt    = '0;
            end else begin
              w_cl_nxt = r_cl - CNT_W'(1);
            end
          end else if (stop) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        w_en = 1'b1;
        if (w_last) begin
          w_wrap_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
          w_cl_nxt    = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_idx       = johnson_index(JOHNSON_MAX_WIDTH'(q), WIDTH);
  assign phase       = {{(SEQ_LEN-1){1'b0}}, 1'b1} << w_idx;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign wrap        = r_wrap;
  assign cycles_left = r_cl;

endmodule

`default_nettype wire

// File: tb/tb_johnson_seq_ctrl.sv
// ============================================================================
//  tb_johnson_seq_ctrl
//  Scoreboard bench for the Johnson sequencer at WIDTH=4, CNT_W=8.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_johnson_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       dir;
  logic [7:0] cycles;
  logic [3:0] q;
  logic [7:0] phase;
  logic       wrap;
  logic       busy;
  logic       done;
  logic [7:0] cycles_left;

  johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .dir         (dir),
    .cycles      (cycles),
    .q           (q),
    .phase       (phase),
    .wrap        (wrap),
    .busy        (busy),
    .done        (done),
    .cycles_left (cycles_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] q;
    logic [7:0] phase;
    logic       wrap;
    logic       busy;
    logic       done;
    logic [7:0] cl;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: position index, state (0 idle, 1 run, 2 drain), counters.
  int         m_st = 0;
  int         m_k  = 0;
  logic       m_dir = 1'b0;
  int         m_cl = 0;
  logic       m_done = 1'b0;
  logic       m_wrap = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] q_of(input int k);
    case (k)
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0011;
      3: return 4'b0111;
      4: return 4'b1111;
      5: return 4'b1110;
      6: return 4'b1100;
      7: return 4'b1000;
      default: return 4'bxxxx;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic s, input logic sp,
                            input logic d, input logic [7:0] c);
    m_done = 1'b0;
    m_wrap = 1'b0;
    if (!r) begin
      m_st = 0; m_k = 0; m_cl = 0; m_dir = 1'b0;
    end else if (m_st == 0) begin
      if (s && !sp) begin
        if (c != 0) begin
          m_cl = int'(c); m_dir = d; m_st = 1;
        end else begin
          m_done = 1'b1;
        end
      end
    end else if (m_st == 1 && sp && m_k == 0) begin
      m_st = 0; m_done = 1'b1; m_cl = 0;
    end else begin
      m_k = m_dir ? (m_k + 7) % 8 : (m_k + 1) % 8;
      if (m_k == 0) begin
        m_wrap = 1'b1;
        if (m_st == 2 || sp || m_cl == 1) begin
          m_st = 0; m_done = 1'b1; m_cl = 0;
        end else begin
          m_cl = m_cl - 1;
        end
      end else if (m_st == 1 && sp) begin
        m_st = 2;
      end
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic sp,
                      input logic d, input logic [7:0] c);
    exp_t e;
    rst_n = r; start = s; stop = sp; dir = d; cycles = c;
    model_step(r, s, sp, d, c);
    e.q     = q_of(m_k);
    e.phase = 8'(1) << m_k;
    e.wrap  = m_wrap;
    e.busy  = (m_st != 0);
    e.done  = m_done;
    e.cl    = 8'(m_cl);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("q",           32'(q),           32'(e.q));
    check("phase",       32'(phase),       32'(e.phase));
    check("wrap",        32'(wrap),        32'(e.wrap));
    check("busy",        32'(busy),        32'(e.busy));
    check("done",        32'(done),        32'(e.done));
    check("cycles_left", 32'(cycles_left), 32'(e.cl));
  endtask

  logic [3:0] fwd_seq [8];
  int n_wrap;
  int done_at;

  initial begin
    fwd_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; cycles = 8'd0;

    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("rst_phase", 32'(phase), 32'h1);
    tick(1, 0, 0, 0, 0);

    // One forward revolution.
    tick(1, 1, 0, 0, 8'd1);
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 0, 0, 0);
      check("t1_seq", 32'(q), 32'(fwd_seq[i]));
    end
    check("t1_done", 32'(done), 32'h1);
    tick(1, 0, 0, 0, 0);
    check("t1_busy_after", 32'(busy), 32'h0);

    // Three reverse revolutions.
    tick(1, 1, 0, 1, 8'd3);
    n_wrap = 0;
    for (int i = 0; i < 24; i++) begin
      tick(1, 0, 0, 0, 0);
      if (i == 0) check("t2_first_q", 32'(q), 32'h8);
      if (wrap) n_wrap++;
    end
    check("t2_wraps", 32'(n_wrap), 32'd3);
    check("t2_done", 32'(done), 32'h1);
    tick(1, 0, 0, 0, 0);

    // Graceful stop in the first of two revolutions.
    tick(1, 1, 0, 0, 8'd2);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0);
    check("t3_q_at_stop", 32'(q), 32'h7);
    tick(1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 0);
    check("t3_done", 32'(done), 32'h1);
    check("t3_cl", 32'(cycles_left), 32'h0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0);

    // Zero-revolution start, then start+stop together.
    tick(1, 1, 0, 0, 8'd0);
    check("t4_done", 32'(done), 32'h1);
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 8'd5);
    tick(1, 0, 0, 0, 0);

    // Reset mid-run at 1110, then a fresh run.
    tick(1, 1, 0, 0, 8'd1);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0);
    check("t5_q_pre", 32'(q), 32'he);
    tick(0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 8'd1);
    for (int i = 0; i < 9; i++) tick(1, 0, 0, 0, 0);

    // start held and dir/cycles toggled during a run.
    tick(1, 1, 0, 0, 8'd2);
    done_at = -1;
    for (int i = 0; i < 18; i++) begin
      tick(1, 1, 0, logic'(i % 2), 8'($urandom_range(0, 255)));
      if (done && done_at < 0) done_at = i;
    end
    check("t6_done_at", 32'(done_at), 32'd15);
    start = 1'b0;
    tick(1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
- Controller that sequences a Johnson (twisted-ring) shift register as a multi-phase timing generator.
- Accepts a run command with a revolution count and direction, then steps the ring every clock.
- Emits the raw ring value, a one-hot phase decode and a wrap pulse per revolution.
- Signals completion with a single-cycle done pulse; supports graceful stop at the next revolution boundary.

Parameters:
WIDTH, 4, ring width in bits; the sequence has 2*WIDTH states; legal range 2..16
CNT_W, 8, width of the revolution count

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  run request, sampled only in IDLE
stop  input  1  graceful stop request, sampled in RUN
dir  input  1  0 = forward, 1 = reverse; latched at start
cycles  input  CNT_W  number of full revolutions to run; latched at start
q  output  WIDTH  current ring value
phase  output  2*WIDTH  one-hot index of q within the forward sequence
wrap  output  1  one-cycle pulse on the edge where q returns to all-zeros
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle completion pulse
cycles_left  output  CNT_W  revolutions remaining

Behaviour:
- Reset, synchronous on rst_n==0 at a clk edge:
  - state=IDLE, q=0, busy=0, done=0, wrap=0, cycles_left=0, phase=1 (bit 0).
  - A reset mid-run aborts immediately and no done pulse is issued.
- Forward step: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}. WIDTH=4 sequence: 0000,0001,0011,0111,1111,1110,1100,1000, then 0000.
- Reverse step: q <= {~q[0], q[WIDTH-1:1]}. WIDTH=4 sequence: 0000,1000,1100,1110,1111,0111,0011,0001, then 0000.
- phase is a combinational decode of q. Let p = popcount(q):
  - q[WIDTH-1]==0 → index = p.
  - q[WIDTH-1]==1 → index = 2*WIDTH - p.
  - Reverse therefore walks the index 0, 7, 6, …, 1.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE, start=1 and cycles!=0: latch cycles into cycles_left, latch dir, go to RUN, busy=1. q stays 0 on this edge; the first step occurs on the next edge.
  - IDLE, start=1 and cycles==0: done=1 on the next edge, stay in IDLE, q untouched.
  - IDLE, start=1 and stop=1 together: stop has priority and nothing happens.
  - RUN: q steps every edge. On the edge where the stepped q becomes 0: wrap=1 and cycles_left decrements.
  - RUN, decrement reaches 0: on that same edge go to IDLE, done=1, busy=0. A run therefore takes 2*WIDTH*cycles edges after entry to RUN.
  - RUN, stop=1 with q!=0: go to DRAIN. Keep stepping until the next wrap, then go to IDLE with done=1 and cycles_left forced to 0.
  - RUN, stop=1 with q==0 (the first RUN cycle): go to IDLE on the next edge with done=1 and no step.
  - RUN, stop coinciding with the final wrap: normal completion, single done pulse.
- Ignored inputs:
  - start in RUN or DRAIN.
  - stop in DRAIN.
  - dir and cycles changes after latch.
- Other rules:
  - wrap and done are registered one-cycle pulses.
  - cycles_left never underflows.
  - q is written only by the ring core, so illegal non-Johnson values are unreachable; no recovery logic is required.

Decomposition:
- Shared package johnson_pkg contains:
  - the FSM state enum {IDLE, RUN, DRAIN};
  - function johnson_index(q), returning the index 0..2*WIDTH-1;
  - localparam for the sequence length, 2*WIDTH.
- Sub-module johnson_core (ports clk, rst_n, en, dir, q):
  - holds the ring register and performs the step when en=1;
  - the controller drives en=1 in RUN and DRAIN.
- The controller owns the FSM, the counters and the phase decode.

Test Plan:
- Reset, then start=1, cycles=1, dir=0 (WIDTH=4) → q walks 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; phase walks bits 1..7 then 0; wrap and done both high on the 8th edge after entering RUN; busy low afterwards.
- start=1, cycles=3, dir=1 → q follows the reverse sequence (1000 first); three wrap pulses 8 edges apart; cycles_left goes 3, 2, 1, 0; done coincides with the third wrap, 24 edges total.
- cycles=2, stop asserted when q=0111 in the first revolution → enters DRAIN and continues 1111…0000; done on that wrap; cycles_left=0; no second revolution.
- start=1, cycles=0 → done pulse one edge later, busy never rises, q stays 0000.
- rst_n=0 for one edge while q=1110 in RUN → next cycle shows q=0000, busy=0, no done; a fresh start then runs normally.
- start=1 asserted during RUN, and dir toggled mid-run → neither has any effect on sequence or timing.
